// File: rtl/sprite_pass_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_pass_scheduler
// Owns the shared VGA pixel-write port. One pass visits every sprite animator
// in index order: a one-cycle EN grant, then the sprite's pixel stream is
// forwarded until it pulses finish (or the per-sprite watchdog expires), then
// the next sprite is granted. A pass ends with a one-cycle pass_done pulse.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   go                 start a pass (sampled only while idle)
//   en[N]              one-hot start pulse to the current sprite
//   finish[N]          per-sprite done pulse
//   plot_in/x_in/y_in/colour_in   packed per-sprite pixel buses
//   plot/x/y/colour    forwarded pixel stream to the VGA adapter
//   cur_idx            index of the sprite currently owning the port
//   busy               high whenever a pass is in progress
//   pass_done          one-cycle pulse at the end of a pass
//   timeout_err        sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module sprite_pass_scheduler #(
    parameter int unsigned N_SPRITES = 8,
    parameter int unsigned TIMEOUT   = 500000,
    localparam int unsigned IW       = $clog2(N_SPRITES)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   go,
    output logic [N_SPRITES-1:0]   en,
    input  logic [N_SPRITES-1:0]   finish,
    input  logic [N_SPRITES-1:0]   plot_in,
    input  logic [8*N_SPRITES-1:0] x_in,
    input  logic [7*N_SPRITES-1:0] y_in,
    input  logic [3*N_SPRITES-1:0] colour_in,
    output logic                   plot,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic [IW-1:0]          cur_idx,
    output logic                   busy,
    output logic                   pass_done,
    output logic                   timeout_err
);

    localparam int unsigned CW       = 20;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SPRITES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cur_idx_q, cur_idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic            fin_cur;

    // State, owner index, watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cur_idx_q <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // Select the current owner's finish bit; other sprites' pulses never matter.
    always_comb begin
        fin_cur = 1'b0;
        for (int unsigned i = 0; i < N_SPRITES; i++) begin
            if (IW'(i) == cur_idx_q) begin
                fin_cur = finish[i];
            end
        end
    end

    // Next-state logic for the grant / run / advance sequence.
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Hold at the limit so the counter can never wrap.
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // A finish on the limit cycle takes priority over the watchdog.
                if (fin_cur) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cur_idx_q == LAST_IDX) begin
                    cur_idx_d = '0;
                    state_d   = S_DONE;
                end else begin
                    cur_idx_d = cur_idx_q + IW'(1);
                    state_d   = S_GRANT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and grant outputs decoded from registered state only.
    always_comb begin
        en = '0;
        for (int unsigned i = 0; i < N_SPRITES; i++) begin
            if ((state_q == S_GRANT) && (IW'(i) == cur_idx_q)) begin
                en[i] = 1'b1;
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign pass_done   = (state_q == S_DONE);
    assign timeout_err = tmo_q;
    assign cur_idx     = cur_idx_q;

    // Zero-latency pixel mux; colour passes through even when plot is low.
    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        if (state_q == S_RUN) begin
            for (int unsigned i = 0; i < N_SPRITES; i++) begin
                if (IW'(i) == cur_idx_q) begin
                    plot   = plot_in[i];
                    x      = x_in[8*i +: 8];
                    y      = y_in[7*i +: 7];
                    colour = colour_in[3*i +: 3];
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_pass_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_pass_scheduler
// Each pass is expanded up front into a per-cycle timeline (idle, grant,
// run cycles, advance, done) from the sprite finish delays and the timeout
// rule. The bench walks that timeline, drives finish/pixel inputs from it and
// compares every DUT output against the timeline entry each cycle.
// ---------------------------------------------------------------------------
module tb_sprite_pass_scheduler;

    localparam int N   = 8;
    localparam int TMO = 16;

    localparam int K_IDLE  = 0;
    localparam int K_GRANT = 1;
    localparam int K_RUN   = 2;
    localparam int K_NEXT  = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int kind;
        int idx;
        bit fin;   // owner raises finish on this run cycle
        bit tmo;   // last run cycle of a sprite that never finished in time
        bit go;    // go value for idle cycles
    } rec_t;

    logic          clk;
    logic          resetn;
    logic          go;
    logic [N-1:0]  en;
    logic [N-1:0]  finish;
    logic [N-1:0]  plot_in;
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic          plot;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic [2:0]    cur_idx;
    logic          busy;
    logic          pass_done;
    logic          timeout_err;

    int   n_vec;
    int   n_err;
    bit   tmo_m;
    rec_t q[$];

    bit        pp [N];
    logic [7:0] px [N];
    logic [6:0] py [N];
    logic [2:0] pc [N];

    sprite_pass_scheduler #(
        .N_SPRITES (N),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .en          (en),
        .finish      (finish),
        .plot_in     (plot_in),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .cur_idx     (cur_idx),
        .busy        (busy),
        .pass_done   (pass_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: sim did not finish, got running want done");
        $fatal(1);
    end

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back('{kind:K_IDLE, idx:0, fin:1'b0, tmo:1'b0, go:1'b0});
    endfunction

    // d[i] = run cycle on which sprite i finishes (1-based); 0 or > TMO = never in time.
    function automatic void add_pass(input int d [N]);
        int  len;
        bit  ok;
        q.push_back('{kind:K_IDLE, idx:0, fin:1'b0, tmo:1'b0, go:1'b1});
        for (int i = 0; i < N; i++) begin
            ok  = (d[i] >= 1) && (d[i] <= TMO);
            len = ok ? d[i] : TMO;
            q.push_back('{kind:K_GRANT, idx:i, fin:1'b0, tmo:1'b0, go:1'b0});
            for (int r = 1; r <= len; r++)
                q.push_back('{kind:K_RUN, idx:i, fin:(ok && r == d[i]), tmo:(!ok && r == len), go:1'b0});
            q.push_back('{kind:K_NEXT, idx:i, fin:1'b0, tmo:1'b0, go:1'b0});
        end
        q.push_back('{kind:K_DONE, idx:0, fin:1'b0, tmo:1'b0, go:1'b0});
    endfunction

    task automatic drive_pixels(input bit fixed_mux);
        for (int i = 0; i < N; i++) begin
            if (fixed_mux) begin
                pp[i] = (i == 3);
                px[i] = (i == 3) ? 8'd107 : 8'd255;
                py[i] = (i == 3) ? 7'd90  : 7'd0;
                pc[i] = (i == 3) ? 3'b100 : 3'b111;
            end else begin
                pp[i] = 1'($urandom);
                px[i] = 8'($urandom);
                py[i] = 7'($urandom);
                pc[i] = 3'($urandom);
            end
            plot_in[i]         = pp[i];
            x_in[8*i +: 8]     = px[i];
            y_in[7*i +: 7]     = py[i];
            colour_in[3*i +: 3] = pc[i];
        end
    endtask

    // Walk the timeline; abort_at >= 0 asserts reset in the middle of that cycle.
    task automatic run_q(input int abort_at, input bit fixed_mux);
        rec_t       r;
        logic [7:0] e_en;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        logic [2:0] e_idx;
        for (int k = 0; k < q.size(); k++) begin
            r  = q[k];
            go = (r.kind == K_IDLE) ? r.go : 1'($urandom);
            finish = 8'($urandom);
            if (r.kind == K_RUN) finish[r.idx] = r.fin;
            drive_pixels(fixed_mux);
            #1;
            e_en   = (r.kind == K_GRANT) ? (8'd1 << r.idx) : 8'd0;
            e_plot = (r.kind == K_RUN) ? pp[r.idx] : 1'b0;
            e_x    = (r.kind == K_RUN) ? px[r.idx] : 8'd0;
            e_y    = (r.kind == K_RUN) ? py[r.idx] : 7'd0;
            e_c    = (r.kind == K_RUN) ? pc[r.idx] : 3'd0;
            e_idx  = (r.kind == K_GRANT || r.kind == K_RUN || r.kind == K_NEXT) ? 3'(r.idx) : 3'd0;
            n_vec++; if (en !== e_en) begin n_err++; $display("FAIL en cyc%0d: got %b want %b", k, en, e_en); end
            n_vec++; if (plot !== e_plot) begin n_err++; $display("FAIL plot cyc%0d: got %b want %b", k, plot, e_plot); end
            n_vec++; if (x !== e_x) begin n_err++; $display("FAIL x cyc%0d: got %0d want %0d", k, x, e_x); end
            n_vec++; if (y !== e_y) begin n_err++; $display("FAIL y cyc%0d: got %0d want %0d", k, y, e_y); end
            n_vec++; if (colour !== e_c) begin n_err++; $display("FAIL colour cyc%0d: got %b want %b", k, colour, e_c); end
            n_vec++; if (cur_idx !== e_idx) begin n_err++; $display("FAIL cur_idx cyc%0d: got %0d want %0d", k, cur_idx, e_idx); end
            n_vec++; if (busy !== (r.kind != K_IDLE)) begin n_err++; $display("FAIL busy cyc%0d: got %b want %b", k, busy, r.kind != K_IDLE); end
            n_vec++; if (pass_done !== (r.kind == K_DONE)) begin n_err++; $display("FAIL pass_done cyc%0d: got %b want %b", k, pass_done, r.kind == K_DONE); end
            n_vec++; if (timeout_err !== tmo_m) begin n_err++; $display("FAIL timeout_err cyc%0d: got %b want %b", k, timeout_err, tmo_m); end
            if (k == abort_at) begin
                #1 resetn = 1'b0;
                #1;
                n_vec++; if (en !== 8'd0) begin n_err++; $display("FAIL rst_mid_en: got %b want 0", en); end
                n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL rst_mid_plot: got %b want 0", plot); end
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
                n_vec++; if (cur_idx !== 3'd0) begin n_err++; $display("FAIL rst_mid_idx: got %0d want 0", cur_idx); end
                n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_tmo: got %b want 0", timeout_err); end
                @(posedge clk); #1;
                resetn = 1'b1;
                tmo_m  = 1'b0;
                q.delete();
                return;
            end
            @(posedge clk); #1;
            if (r.tmo) tmo_m = 1'b1;
        end
        q.delete();
    endtask

    function automatic void rand_delays(output int d [N]);
        for (int i = 0; i < N; i++) d[i] = $urandom_range(1, TMO - 1);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            go = 1'($urandom);
            finish = 8'($urandom);
            drive_pixels(1'b0);
            @(posedge clk); #1;
            n_vec++; if (en !== 8'd0) begin n_err++; $display("FAIL rst_en: got %b want 0", en); end
            n_vec++; if ({plot, x, y, colour} !== 19'd0) begin n_err++; $display("FAIL rst_pix: got %h want 0", {plot, x, y, colour}); end
            n_vec++; if (cur_idx !== 3'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", cur_idx); end
            n_vec++; if ({busy, pass_done, timeout_err} !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b want 000", {busy, pass_done, timeout_err}); end
        end
        go     = 1'b0;
        resetn = 1'b1;
        tmo_m  = 1'b0;
        @(posedge clk); #1;
    endtask

    // Finish on run cycle 11 -> grants 13 cycles apart.
    task automatic test_full_pass();
        int d [N];
        for (int i = 0; i < N; i++) d[i] = 11;
        add_pass(d);
        add_idle(3);
        run_q(-1, 1'b0);
    endtask

    task automatic test_mux();
        int d [N];
        rand_delays(d);
        add_pass(d);
        add_idle(2);
        run_q(-1, 1'b1);
    endtask

    // Random stray finishes throughout; sprite 4 finishes on the watchdog limit cycle.
    task automatic test_stray_coincident();
        int d [N];
        rand_delays(d);
        d[0] = TMO - 1;
        d[4] = TMO;
        add_pass(d);
        add_idle(2);
        run_q(-1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d [N];
        rand_delays(d);
        add_pass(d);
        rand_delays(d);
        add_pass(d);
        add_idle(2);
        run_q(-1, 1'b0);
    endtask

    // Sprite 5 never finishes; flag stays set through a later clean pass.
    task automatic test_watchdog();
        int d [N];
        rand_delays(d);
        d[5] = 0;
        add_pass(d);
        add_idle(1);
        rand_delays(d);
        add_pass(d);
        add_idle(2);
        run_q(-1, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        int d [N];
        int cnt;
        int at;
        for (int i = 0; i < N; i++) d[i] = 5;
        add_pass(d);
        cnt = 0;
        at  = -1;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].kind == K_RUN && q[k].idx == 4) begin
                cnt++;
                if (cnt == 3) at = k;
            end
        end
        run_q(at, 1'b0);
        rand_delays(d);
        add_pass(d);
        add_idle(2);
        run_q(-1, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        tmo_m     = 1'b0;
        resetn    = 1'b0;
        go        = 1'b0;
        finish    = '0;
        plot_in   = '0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        #1;
        test_reset();
        test_full_pass();
        test_mux();
        test_stray_coincident();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
